// File: rtl/ex_mem_branch_stage_pkg.sv
// Shared definitions for the EX/MEM branch stage.
// Holds the funct3 branch encodings, the stage FSM state type and the
// control-bit bundle that travels with an instruction into MEM.
package ex_mem_branch_stage_pkg;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    // StShadow marks the one EX slot that follows an issued redirect.
    typedef enum logic {StRun, StShadow} state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/ex_mem_branch_stage_if.sv
// Bundle of EX-side inputs and MEM/redirect-side outputs of the EX/MEM stage.
// slave  : used by the stage (consumes ex_*, mem_stall; drives mem_*, redirect, counter)
// master : used by the surrounding pipeline / testbench
interface ex_mem_branch_stage_if #(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 16
);
    logic             ex_valid;
    logic [N-1:0]     ex_alu_y;
    logic             ex_zf;
    logic             ex_cf;
    logic             ex_vf;
    logic             ex_sf;
    logic             ex_branch;
    logic             ex_jump;
    logic [2:0]       ex_funct3;
    logic [N-1:0]     ex_target;
    logic [N-1:0]     ex_pc_plus4;
    logic [N-1:0]     ex_rs2_data;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_mem_to_reg;
    logic             mem_stall;

    logic             mem_valid;
    logic [N-1:0]     mem_alu_y;
    logic [N-1:0]     mem_rs2_data;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic             mem_mem_write;
    logic             mem_mem_to_reg;
    logic             redirect_valid;
    logic [N-1:0]     redirect_pc;
    logic             misaligned_target;
    logic [CNT_W-1:0] taken_cnt;

    modport slave (
        input  ex_valid, ex_alu_y, ex_zf, ex_cf, ex_vf, ex_sf, ex_branch, ex_jump,
               ex_funct3, ex_target, ex_pc_plus4, ex_rs2_data, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, mem_stall,
        output mem_valid, mem_alu_y, mem_rs2_data, mem_rd, mem_reg_write, mem_mem_read,
               mem_mem_write, mem_mem_to_reg, redirect_valid, redirect_pc,
               misaligned_target, taken_cnt
    );

    modport master (
        output ex_valid, ex_alu_y, ex_zf, ex_cf, ex_vf, ex_sf, ex_branch, ex_jump,
               ex_funct3, ex_target, ex_pc_plus4, ex_rs2_data, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, mem_stall,
        input  mem_valid, mem_alu_y, mem_rs2_data, mem_rd, mem_reg_write, mem_mem_read,
               mem_mem_write, mem_mem_to_reg, redirect_valid, redirect_pc,
               misaligned_target, taken_cnt
    );

endinterface

// File: rtl/ex_mem_branch_stage_branch_cond.sv
// Combinational branch condition from funct3 and subtract flags.
// funct3_i        : branch type
// zf_i/cf_i/vf_i/sf_i : flags of rs1 - rs2 (cf=1 means no borrow)
// cond_o          : condition true; reserved encodings 010/011 are never true
module ex_mem_branch_stage_branch_cond
    import ex_mem_branch_stage_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       zf_i,
    input  logic       cf_i,
    input  logic       vf_i,
    input  logic       sf_i,
    output logic       cond_o
);

    always_comb begin
        cond_o = 1'b0;
        case (funct3_i)
            F3Beq:   cond_o = zf_i;
            F3Bne:   cond_o = ~zf_i;
            F3Blt:   cond_o = sf_i ^ vf_i;
            F3Bge:   cond_o = ~(sf_i ^ vf_i);
            F3Bltu:  cond_o = ~cf_i;
            F3Bgeu:  cond_o = cf_i;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with branch/jump resolution.
// clk, rst_n : clock and asynchronous active-low reset
// bus        : ex_* inputs and mem_stall in; registered mem_* outputs, one-cycle
//              PC redirect, misaligned-target flag and saturating taken counter out
module ex_mem_branch_stage
    import ex_mem_branch_stage_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ex_mem_branch_stage_if.slave  bus
);

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [N-1:0]     alu_y_q, alu_y_d;
    logic [N-1:0]     rs2_q, rs2_d;
    logic [4:0]       rd_q, rd_d;
    logic             redir_v_q, redir_v_d;
    logic [N-1:0]     redir_pc_q, redir_pc_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic live;
    logic cond;
    logic taken;

    ex_mem_branch_stage_branch_cond u_branch_cond (
        .funct3_i (bus.ex_funct3),
        .zf_i     (bus.ex_zf),
        .cf_i     (bus.ex_cf),
        .vf_i     (bus.ex_vf),
        .sf_i     (bus.ex_sf),
        .cond_o   (cond)
    );

    assign accept = ~bus.mem_stall;
    // The slot right after a redirect is wrong-path and never becomes live.
    assign live   = bus.ex_valid & (state_q == StRun);
    assign taken  = live & (bus.ex_jump | (bus.ex_branch & cond));

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        alu_y_d    = alu_y_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        redir_pc_d = redir_pc_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;
        // Pulse lasts one cycle even if MEM stalls right after.
        redir_v_d  = accept & taken;

        if (accept) begin
            valid_d    = live;
            ctrl_d     = '0;
            if (live) begin
                ctrl_d = '{reg_write:  bus.ex_reg_write,
                           mem_read:   bus.ex_mem_read,
                           mem_write:  bus.ex_mem_write,
                           mem_to_reg: bus.ex_mem_to_reg};
            end
            alu_y_d    = bus.ex_jump ? bus.ex_pc_plus4 : bus.ex_alu_y;
            rs2_d      = bus.ex_rs2_data;
            rd_d       = bus.ex_rd;
            misalign_d = taken & (|bus.ex_target[1:0]);
            if (taken) begin
                redir_pc_d = bus.ex_target;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            unique case (state_q)
                StRun:    state_d = taken ? StShadow : StRun;
                StShadow: state_d = StRun;
                default:  state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            alu_y_q    <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            redir_v_q  <= 1'b0;
            redir_pc_q <= '0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            alu_y_q    <= alu_y_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            redir_v_q  <= redir_v_d;
            redir_pc_q <= redir_pc_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.mem_valid         = valid_q;
    assign bus.mem_alu_y         = alu_y_q;
    assign bus.mem_rs2_data      = rs2_q;
    assign bus.mem_rd            = rd_q;
    assign bus.mem_reg_write     = ctrl_q.reg_write;
    assign bus.mem_mem_read      = ctrl_q.mem_read;
    assign bus.mem_mem_write     = ctrl_q.mem_write;
    assign bus.mem_mem_to_reg    = ctrl_q.mem_to_reg;
    assign bus.redirect_valid    = redir_v_q;
    assign bus.redirect_pc       = redir_pc_q;
    assign bus.misaligned_target = misalign_q;
    assign bus.taken_cnt         = cnt_q;

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Directed testbench for ex_mem_branch_stage (counter narrowed to 4 bits).
module tb_ex_mem_branch_stage;

    localparam int unsigned N     = 32;
    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   exp_cnt;

    ex_mem_branch_stage_if #(.N(N), .CNT_W(CNT_W)) bus ();

    ex_mem_branch_stage #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.ex_valid      = 1'b0;
        bus.ex_alu_y      = '0;
        bus.ex_zf         = 1'b0;
        bus.ex_cf         = 1'b0;
        bus.ex_vf         = 1'b0;
        bus.ex_sf         = 1'b0;
        bus.ex_branch     = 1'b0;
        bus.ex_jump       = 1'b0;
        bus.ex_funct3     = 3'b000;
        bus.ex_target     = '0;
        bus.ex_pc_plus4   = '0;
        bus.ex_rs2_data   = '0;
        bus.ex_rd         = '0;
        bus.ex_reg_write  = 1'b0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_mem_write  = 1'b0;
        bus.ex_mem_to_reg = 1'b0;
        bus.mem_stall     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        #2;
        n_cmp++; if (bus.mem_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_mem_valid got %0b want 0", bus.mem_valid); end
        n_cmp++; if (bus.mem_alu_y !== 32'h0) begin n_err++;
            $display("FAIL reset_mem_alu_y got %h want 0", bus.mem_alu_y); end
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_redirect_valid got %0b want 0", bus.redirect_valid); end
        n_cmp++; if (bus.redirect_pc !== 32'h0) begin n_err++;
            $display("FAIL reset_redirect_pc got %h want 0", bus.redirect_pc); end
        n_cmp++; if (bus.taken_cnt !== 4'h0) begin n_err++;
            $display("FAIL reset_taken_cnt got %0d want 0", bus.taken_cnt); end
        n_cmp++; if (bus.misaligned_target !== 1'b0) begin n_err++;
            $display("FAIL reset_misaligned got %0b want 0", bus.misaligned_target); end
        #10;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_beq();
        drive_idle();
        bus.ex_valid  = 1'b1;
        bus.ex_branch = 1'b1;
        bus.ex_funct3 = 3'b000;
        bus.ex_zf     = 1'b1;
        bus.ex_target = 32'h100;
        bus.ex_rd     = 5'd5;
        step();
        exp_cnt = 1;
        n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_err++;
            $display("FAIL beq_redirect got %0b want 1", bus.redirect_valid); end
        n_cmp++; if (bus.redirect_pc !== 32'h100) begin n_err++;
            $display("FAIL beq_redirect_pc got %h want 100", bus.redirect_pc); end
        n_cmp++; if (bus.mem_valid !== 1'b1 || bus.mem_rd !== 5'd5) begin n_err++;
            $display("FAIL beq_mem got v=%0b rd=%0d want v=1 rd=5", bus.mem_valid, bus.mem_rd); end
        n_cmp++; if (bus.taken_cnt !== 4'd1) begin n_err++;
            $display("FAIL beq_cnt got %0d want 1", bus.taken_cnt); end
        drive_idle();
        bus.ex_valid     = 1'b1;
        bus.ex_reg_write = 1'b1;
        bus.ex_rd        = 5'd7;
        bus.ex_alu_y     = 32'h55;
        step();
        n_cmp++; if (bus.mem_valid !== 1'b0 || bus.mem_reg_write !== 1'b0) begin n_err++;
            $display("FAIL beq_squash got v=%0b rw=%0b want 0 0", bus.mem_valid, bus.mem_reg_write); end
        n_cmp++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h100) begin n_err++;
            $display("FAIL beq_redirect_clear got %0b %h want 0 100", bus.redirect_valid, bus.redirect_pc); end
        step();
        n_cmp++; if (bus.mem_valid !== 1'b1 || bus.mem_reg_write !== 1'b1 || bus.mem_alu_y !== 32'h55) begin
            n_err++;
            $display("FAIL beq_after got v=%0b rw=%0b y=%h want 1 1 55",
                     bus.mem_valid, bus.mem_reg_write, bus.mem_alu_y); end
    endtask

    task automatic test_branch_conds();
        // {funct3, zf, cf, vf, sf, expected taken}
        logic [7:0] vec [8];
        logic [7:0] v;
        vec[0] = {3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // BLTU cf=1
        vec[1] = {3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}; // BGE sf=vf=1
        vec[2] = {3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // BLT sf=1 vf=0
        vec[3] = {3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; // reserved
        vec[4] = {3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // reserved
        vec[5] = {3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // BNE zf=0
        vec[6] = {3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}; // BGEU cf=1
        vec[7] = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // BEQ zf=0
        for (int i = 0; i < 8; i++) begin
            v = vec[i];
            drive_idle();
            bus.ex_valid  = 1'b1;
            bus.ex_branch = 1'b1;
            bus.ex_funct3 = v[7:5];
            bus.ex_zf     = v[4];
            bus.ex_cf     = v[3];
            bus.ex_vf     = v[2];
            bus.ex_sf     = v[1];
            bus.ex_target = 32'h1000 + 32'(i * 4);
            step();
            if (v[0]) exp_cnt++;
            n_cmp++; if (bus.redirect_valid !== v[0]) begin n_err++;
                $display("FAIL cond_%0d got %0b want %0b", i, bus.redirect_valid, v[0]); end
            drive_idle();
            step();
        end
        n_cmp++; if (bus.taken_cnt !== 4'(exp_cnt)) begin n_err++;
            $display("FAIL cond_cnt got %0d want %0d", bus.taken_cnt, exp_cnt); end
    endtask

    task automatic test_jal();
        drive_idle();
        bus.ex_valid     = 1'b1;
        bus.ex_jump      = 1'b1;
        bus.ex_branch    = 1'b1;
        bus.ex_funct3    = 3'b010;
        bus.ex_pc_plus4  = 32'h24;
        bus.ex_alu_y     = 32'hDEAD;
        bus.ex_target    = 32'h102;
        bus.ex_rd        = 5'd1;
        bus.ex_reg_write = 1'b1;
        step();
        exp_cnt++;
        n_cmp++; if (bus.mem_alu_y !== 32'h24) begin n_err++;
            $display("FAIL jal_link got %h want 24", bus.mem_alu_y); end
        n_cmp++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h102) begin n_err++;
            $display("FAIL jal_redirect got %0b %h want 1 102", bus.redirect_valid, bus.redirect_pc); end
        n_cmp++; if (bus.misaligned_target !== 1'b1) begin n_err++;
            $display("FAIL jal_misaligned got %0b want 1", bus.misaligned_target); end
        n_cmp++; if (bus.mem_reg_write !== 1'b1) begin n_err++;
            $display("FAIL jal_reg_write got %0b want 1", bus.mem_reg_write); end
        drive_idle();
        step();
        n_cmp++; if (bus.misaligned_target !== 1'b0 || bus.mem_valid !== 1'b0) begin n_err++;
            $display("FAIL jal_after got mis=%0b v=%0b want 0 0", bus.misaligned_target, bus.mem_valid); end
    endtask

    task automatic test_stall();
        drive_idle();
        bus.ex_valid     = 1'b1;
        bus.ex_alu_y     = 32'h11;
        bus.ex_rd        = 5'd3;
        bus.ex_reg_write = 1'b1;
        step();
        n_cmp++; if (bus.mem_alu_y !== 32'h11) begin n_err++;
            $display("FAIL stall_pre got %h want 11", bus.mem_alu_y); end
        drive_idle();
        bus.ex_valid  = 1'b1;
        bus.ex_branch = 1'b1;
        bus.ex_funct3 = 3'b001;
        bus.ex_target = 32'h200;
        bus.ex_alu_y  = 32'h22;
        bus.ex_rd     = 5'd4;
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_err++;
                $display("FAIL stall_redirect_%0d got %0b want 0", i, bus.redirect_valid); end
            n_cmp++; if (bus.mem_alu_y !== 32'h11 || bus.mem_rd !== 5'd3) begin n_err++;
                $display("FAIL stall_hold_%0d got %h rd=%0d want 11 rd=3", i, bus.mem_alu_y, bus.mem_rd); end
        end
        bus.mem_stall = 1'b0;
        step();
        exp_cnt++;
        n_cmp++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h200) begin n_err++;
            $display("FAIL stall_release got %0b %h want 1 200", bus.redirect_valid, bus.redirect_pc); end
        n_cmp++; if (bus.mem_alu_y !== 32'h22 || bus.mem_rd !== 5'd4) begin n_err++;
            $display("FAIL stall_load got %h rd=%0d want 22 rd=4", bus.mem_alu_y, bus.mem_rd); end
        drive_idle();
        bus.ex_valid     = 1'b1;
        bus.ex_alu_y     = 32'h33;
        bus.ex_rd        = 5'd6;
        bus.ex_reg_write = 1'b1;
        step();
        n_cmp++; if (bus.mem_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin n_err++;
            $display("FAIL stall_squash got v=%0b r=%0b want 0 0", bus.mem_valid, bus.redirect_valid); end
        step();
        n_cmp++; if (bus.mem_valid !== 1'b1 || bus.mem_rd !== 5'd6) begin n_err++;
            $display("FAIL stall_one_slot got v=%0b rd=%0d want 1 6", bus.mem_valid, bus.mem_rd); end
    endtask

    task automatic test_back_to_back();
        drive_idle();
        bus.ex_valid  = 1'b1;
        bus.ex_branch = 1'b1;
        bus.ex_funct3 = 3'b000;
        bus.ex_zf     = 1'b1;
        bus.ex_target = 32'h300;
        step();
        exp_cnt++;
        n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_err++;
            $display("FAIL b2b_first got %0b want 1", bus.redirect_valid); end
        step();
        n_cmp++; if (bus.redirect_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin n_err++;
            $display("FAIL b2b_second got r=%0b v=%0b want 0 0", bus.redirect_valid, bus.mem_valid); end
        step();
        exp_cnt++;
        n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_err++;
            $display("FAIL b2b_third got %0b want 1", bus.redirect_valid); end
        // Stall while in the shadow slot: pulse still drops, squash waits for accept.
        bus.mem_stall = 1'b1;
        step();
        n_cmp++; if (bus.redirect_valid !== 1'b0 || bus.mem_valid !== 1'b1) begin n_err++;
            $display("FAIL b2b_shadow_stall got r=%0b v=%0b want 0 1", bus.redirect_valid, bus.mem_valid); end
        bus.mem_stall = 1'b0;
        step();
        n_cmp++; if (bus.mem_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin n_err++;
            $display("FAIL b2b_shadow_squash got v=%0b r=%0b want 0 0", bus.mem_valid, bus.redirect_valid); end
        drive_idle();
        bus.ex_valid     = 1'b1;
        bus.ex_rd        = 5'd9;
        bus.ex_reg_write = 1'b1;
        step();
        n_cmp++; if (bus.mem_valid !== 1'b1 || bus.mem_rd !== 5'd9) begin n_err++;
            $display("FAIL b2b_resume got v=%0b rd=%0d want 1 9", bus.mem_valid, bus.mem_rd); end
        n_cmp++; if (bus.taken_cnt !== 4'(exp_cnt)) begin n_err++;
            $display("FAIL b2b_cnt got %0d want %0d", bus.taken_cnt, exp_cnt); end
    endtask

    task automatic test_reset_shadow();
        drive_idle();
        bus.ex_valid    = 1'b1;
        bus.ex_jump     = 1'b1;
        bus.ex_target   = 32'h40;
        bus.ex_pc_plus4 = 32'h8;
        step();
        n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_err++;
            $display("FAIL rst_pre got %0b want 1", bus.redirect_valid); end
        #1 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        n_cmp++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0) begin n_err++;
            $display("FAIL rst_redirect got %0b %h want 0 0", bus.redirect_valid, bus.redirect_pc); end
        n_cmp++; if (bus.mem_valid !== 1'b0 || bus.mem_alu_y !== 32'h0 || bus.taken_cnt !== 4'h0) begin
            n_err++;
            $display("FAIL rst_mem got v=%0b y=%h cnt=%0d want 0 0 0",
                     bus.mem_valid, bus.mem_alu_y, bus.taken_cnt); end
        #2 rst_n = 1'b1;
        drive_idle();
        bus.ex_valid  = 1'b1;
        bus.ex_branch = 1'b1;
        bus.ex_funct3 = 3'b000;
        bus.ex_zf     = 1'b1;
        bus.ex_target = 32'h80;
        step();
        exp_cnt++;
        n_cmp++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80) begin n_err++;
            $display("FAIL rst_next_branch got %0b %h want 1 80", bus.redirect_valid, bus.redirect_pc); end
        n_cmp++; if (bus.taken_cnt !== 4'd1) begin n_err++;
            $display("FAIL rst_next_cnt got %0d want 1", bus.taken_cnt); end
        drive_idle();
        step();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
            drive_idle();
            bus.ex_valid  = 1'b1;
            bus.ex_jump   = 1'b1;
            bus.ex_target = 32'h500;
            step();
            if (exp_cnt < 15) exp_cnt++;
            drive_idle();
            step();
        end
        n_cmp++; if (bus.taken_cnt !== 4'hF || exp_cnt != 15) begin n_err++;
            $display("FAIL sat_cnt got %0d want 15", bus.taken_cnt); end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        exp_cnt = 0;
        test_reset();
        test_beq();
        test_branch_conds();
        test_jal();
        test_stall();
        test_back_to_back();
        test_reset_shadow();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
